// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer -- oscilloscope-style triggered capture of the ADC stream.
//
// Once armed, the buffer collects pre_len pre-trigger samples and then waits
// for a threshold crossing. It keeps writing post-trigger samples until
// exactly DEPTH samples are frozen in memory. The capture is then played out
// oldest-first on a valid/ready port.
//
// Optional feature: define ADC_DECIM_EN to add the decim[7:0] input. With it,
// only every (decim+1)-th valid sample is accepted.
//
// Ports
//   adc_clk, rst_n           clock, async active-low reset
//   adc_data, adc_valid      incoming sample stream
//   arm, abort               start capture / return to idle (abort wins)
//   trig_mode, trig_level    00 rise, 01 fall, 10 either, 11 immediate; threshold
//   pre_len                  pre-trigger sample count
//   rd_data/rd_valid/rd_ready/rd_last   playback port
//   busy, triggered, done    status
module adc_capture_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          adc_clk,
    input  logic          rst_n,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic          arm,
    input  logic          abort,
    input  logic [1:0]    trig_mode,
    input  logic [DW-1:0] trig_level,
    input  logic [AW-1:0] pre_len,
`ifdef ADC_DECIM_EN
    input  logic [7:0]    decim,
`endif
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last,
    output logic          busy,
    output logic          triggered,
    output logic          done
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_READ} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, pre_cnt, pre_q, start_addr, rd_addr;
    logic [AW:0]   post_cnt, post_len, rd_cnt;
    logic [1:0]    mode_q;
    logic [DW-1:0] level_q, prev_smp;
    logic          prev_vld;
    logic          active, dec_ok, accept, rise, fall, hit, trig_hit, fetch, xfer;

`ifdef ADC_DECIM_EN
    logic [7:0]    decim_q, dec_cnt;
    assign dec_ok = (dec_cnt == 8'd0);
`else
    assign dec_ok = 1'b1;
`endif

    // pre_len is AW bits wide, so it can never exceed DEPTH-1: the clamp is
    // inherent in the port width.
    assign active   = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    assign accept   = active && adc_valid && dec_ok && !abort;
    assign post_len = DEPTH_W - {1'b0, pre_q};
    assign rd_addr  = start_addr + rd_cnt[AW-1:0];
    assign xfer     = rd_valid && rd_ready;
    // Refill the output register when it is empty or being drained this cycle.
    assign fetch    = (state == S_READ) && (rd_cnt != DEPTH_W) && (!rd_valid || rd_ready) && !abort;
    assign busy     = active;
    assign done     = (state == S_READ);

    always_comb begin
        rise = prev_vld && (prev_smp < level_q) && (adc_data >= level_q);
        fall = prev_vld && (prev_smp >= level_q) && (adc_data < level_q);
        hit  = 1'b0;
        case (mode_q)
            2'b00: hit = rise;
            2'b01: hit = fall;
            2'b10: hit = rise || fall;
            2'b11: hit = 1'b1;
        endcase
        trig_hit = (state == S_ARMED) && accept && hit;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arm) state_nxt = (pre_len == '0) ? S_ARMED : S_PRE;
            S_PRE:   if (accept && (pre_cnt == pre_q - AW'(1))) state_nxt = S_ARMED;
            S_ARMED: if (trig_hit) state_nxt = (post_len == (AW+1)'(1)) ? S_READ : S_POST;
            S_POST:  if (accept && (post_cnt + (AW+1)'(1) == post_len)) state_nxt = S_READ;
            S_READ:  if (xfer && rd_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Capture memory is not reset; only accepted samples are written.
    always_ff @(posedge adc_clk) begin
        if (accept) mem[wr_ptr] <= adc_data;
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            pre_q      <= '0;
            start_addr <= '0;
            rd_cnt     <= '0;
            mode_q     <= '0;
            level_q    <= '0;
            prev_smp   <= '0;
            prev_vld   <= 1'b0;
            triggered  <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr   <= wr_ptr + AW'(1);
                prev_smp <= adc_data;
                prev_vld <= 1'b1;
            end
            if (state == S_IDLE && arm) begin
                pre_q     <= pre_len;
                mode_q    <= trig_mode;
                level_q   <= trig_level;
                prev_vld  <= 1'b0;
                pre_cnt   <= '0;
                post_cnt  <= '0;
                rd_cnt    <= '0;
                triggered <= 1'b0;
            end
            if (state == S_PRE && accept) pre_cnt <= pre_cnt + AW'(1);
            if (trig_hit) begin
                start_addr <= wr_ptr - pre_q;
                triggered  <= 1'b1;
                post_cnt   <= (AW+1)'(1);
            end
            if (state == S_POST && accept) post_cnt <= post_cnt + (AW+1)'(1);
            if (fetch) begin
                rd_data  <= mem[rd_addr];
                rd_valid <= 1'b1;
                rd_last  <= (rd_cnt == DEPTH_W - (AW+1)'(1));
                rd_cnt   <= rd_cnt + (AW+1)'(1);
            end else if (xfer) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            if (xfer && rd_last) triggered <= 1'b0;
            if (abort) begin
                rd_valid  <= 1'b0;
                rd_last   <= 1'b0;
                triggered <= 1'b0;
            end
        end
    end

`ifdef ADC_DECIM_EN
    // Counts valid samples seen while capturing; a sample is accepted when
    // the count is zero, so the first one after arm is always taken.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_q <= '0;
            dec_cnt <= '0;
        end else if (abort) begin
            dec_cnt <= '0;
        end else if (state == S_IDLE && arm) begin
            decim_q <= decim;
            dec_cnt <= '0;
        end else if (active && adc_valid) begin
            dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;
    localparam int DW = 8, DEPTH = 16, AW = 4;
    typedef logic [DW-1:0] samp_t;

    logic          adc_clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] adc_data = '0, trig_level = '0;
    logic          adc_valid = 1'b0, arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [1:0]    trig_mode = '0;
    logic [AW-1:0] pre_len = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, busy, triggered, done;
    int            decim_v = 0;
`ifdef ADC_DECIM_EN
    logic [7:0]    decim;
    assign decim = decim_v[7:0];
    localparam int MAXDEC = 3;
`else
    localparam int MAXDEC = 0;
`endif

    adc_capture_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level),
        .pre_len(pre_len),
`ifdef ADC_DECIM_EN
        .decim(decim),
`endif
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .triggered(triggered), .done(done));

    always #5 adc_clk = ~adc_clk;

    int n_chk = 0, n_pass = 0;
    samp_t exp_q[$];
    bit    expl_q[$];

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: list accepted samples, find the first trigger index at or
    // after pre (the first sample in ARMED), and take the DEPTH-sample window
    // that starts pre samples before it.
    function automatic bit model(input samp_t stim[$], input logic [1:0] mode, input samp_t lvl,
                                 input int pre, input int dec, output samp_t exp[$]);
        samp_t acc[$];
        exp = {};
        for (int k = 0; k < stim.size(); k++)
            if (k % (dec + 1) == 0) acc.push_back(stim[k]);
        for (int i = pre; i < acc.size(); i++) begin
            bit r = 0, f = 0, hit;
            if (i > 0) begin
                r = (acc[i-1] < lvl) && (acc[i] >= lvl);
                f = (acc[i-1] >= lvl) && (acc[i] < lvl);
            end
            case (mode)
                2'b00: hit = r;
                2'b01: hit = f;
                2'b10: hit = r | f;
                default: hit = (i == pre);
            endcase
            if (hit) begin
                if (i - pre + DEPTH > acc.size()) return 0;
                for (int j = 0; j < DEPTH; j++) exp.push_back(acc[i - pre + j]);
                return 1;
            end
        end
        return 0;
    endfunction

    // Monitor: compares every transfer with the scoreboard and checks that a
    // stalled output holds still.
    bit    prev_stall = 0, prev_last = 0;
    samp_t prev_data = '0;
    always @(negedge adc_clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall && rd_valid)
                check(rd_data == prev_data && rd_last == prev_last, "stall_hold",
                      {rd_last, rd_data}, {prev_last, prev_data});
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) check(0, "unexpected_xfer", rd_data, 0);
                else begin
                    samp_t e;
                    bit l;
                    e = exp_q.pop_front();
                    l = expl_q.pop_front();
                    check(rd_data == e && rd_last == l, "playback", {rd_last, rd_data}, {l, e});
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
        end
    end

    task automatic run_capture(input samp_t stim[$], input samp_t exp[$], input logic [1:0] mode,
                               input samp_t lvl, input int pre, input int dec, input int dens,
                               input int rdy_mode, input int abort_after, input bit rst_post);
        int idx = 0, xfers = 0, cyc = 0, trig_seen = 0, done_n = 0;
        bit ended = 0, last_pend = 0;
        if (!rst_post)
            for (int i = 0; i < exp.size() && (abort_after < 0 || i < abort_after); i++) begin
                exp_q.push_back(exp[i]);
                expl_q.push_back(abort_after < 0 && i == DEPTH - 1);
            end
        @(posedge adc_clk); #1;
        arm = 1; abort = 0; trig_mode = mode; trig_level = lvl; pre_len = pre[AW-1:0];
        decim_v = dec; adc_valid = 1; adc_data = samp_t'($urandom); rd_ready = 0;
        @(posedge adc_clk); #1;
        check(busy == 1'b1, "busy_after_arm", busy, 1);
        while (!ended) begin
            // Config inputs and arm wander after arm; the DUT must ignore them.
            arm = ($urandom_range(0, 15) == 0);
            trig_mode = 2'($urandom); trig_level = samp_t'($urandom);
            pre_len = AW'($urandom); decim_v = $urandom_range(0, 7);
            if (idx < stim.size() && $urandom_range(1, 100) <= dens) begin
                adc_valid = 1; adc_data = stim[idx]; idx++;
            end else begin
                adc_valid = 0; adc_data = samp_t'($urandom);
            end
            case (rdy_mode)
                0: rd_ready = 1;
                1: rd_ready = cyc[0];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            abort = 0;
            if (abort_after >= 0 && xfers == abort_after) begin abort = 1; rd_ready = 0; end
            @(negedge adc_clk);
            if (rd_valid && rd_ready) begin xfers++; if (rd_last) last_pend = 1; end
            if (triggered && busy) trig_seen++;
            if (done) begin
                done_n++;
                if (done_n == 1) check(rd_valid == 1'b0, "rd_valid_first_read_cycle", rd_valid, 0);
                if (done_n == 2) check(rd_valid == 1'b1, "rd_valid_second_read_cycle", rd_valid, 1);
            end
            @(posedge adc_clk); #1;
            cyc++;
            if (abort) begin
                check({busy, done, rd_valid, rd_last, triggered} == 5'b0, "idle_after_abort",
                      {busy, done, rd_valid, rd_last, triggered}, 0);
                ended = 1;
            end else if (last_pend) begin
                check({busy, done, rd_valid, rd_last, triggered} == 5'b0, "idle_after_last",
                      {busy, done, rd_valid, rd_last, triggered}, 0);
                ended = 1;
            end else if (rst_post && trig_seen >= 2) begin
                rst_n = 0;
                #1;
                check({rd_data, rd_valid, rd_last, busy, triggered, done} == '0, "async_reset_outputs",
                      {rd_data, rd_valid, rd_last, busy, triggered, done}, 0);
                @(posedge adc_clk); #1;
                rst_n = 1;
                ended = 1;
            end else if (cyc > 4000) begin
                check(0, "capture_timeout", cyc, 4000);
                ended = 1;
            end
        end
        arm = 0; abort = 0; adc_valid = 0; rd_ready = 0;
    endtask

    initial begin
        samp_t ramp[$], stim[$], exp[$];
        bit ok;
        for (int k = 0; k < 200; k++) ramp.push_back(samp_t'(k));

        repeat (3) @(posedge adc_clk);
        #1;
        check({rd_data, rd_valid, rd_last, busy, triggered, done} == '0, "reset_state",
              {rd_data, rd_valid, rd_last, busy, triggered, done}, 0);
        rst_n = 1;

        // Reset asserted in POST, then a normal ramp capture
        ok = model(ramp, 2'b00, 8'd20, 4, 0, exp);
        run_capture(ramp, exp, 2'b00, 8'd20, 4, 0, 100, 0, -1, 1);
        ok = model(ramp, 2'b00, 8'd20, 4, 0, exp);
        run_capture(ramp, exp, 2'b00, 8'd20, 4, 0, 100, 0, -1, 0);

        // Falling edge: equal sample 0x80 is not a falling crossing
        stim = {};
        repeat (10) stim.push_back(8'hFF);
        stim.push_back(8'h80);
        stim.push_back(8'h10);
        repeat (24) stim.push_back(samp_t'($urandom));
        ok = model(stim, 2'b01, 8'h80, 0, 0, exp);
        run_capture(stim, exp, 2'b01, 8'h80, 0, 0, 100, 0, -1, 0);

        // Ready toggling every cycle
        ok = model(ramp, 2'b00, 8'd20, 4, 0, exp);
        run_capture(ramp, exp, 2'b00, 8'd20, 4, 0, 100, 1, -1, 0);

        // Abort in ARMED
        @(posedge adc_clk); #1;
        arm = 1; pre_len = '0; trig_mode = 2'b00; trig_level = 8'hF0; decim_v = 0;
        @(posedge adc_clk); #1;
        arm = 0;
        for (int k = 0; k < 4; k++) begin adc_valid = 1; adc_data = 8'h05; @(posedge adc_clk); #1; end
        check(busy && !triggered, "armed_waiting", {busy, triggered}, 2'b10);
        abort = 1; adc_valid = 0;
        @(posedge adc_clk); #1;
        check({busy, done, rd_valid, triggered} == 4'b0, "abort_armed", {busy, done, rd_valid, triggered}, 0);
        arm = 1;   // abort still high: must win over arm in IDLE
        @(posedge adc_clk); #1;
        arm = 0; abort = 0;
        @(posedge adc_clk); #1;
        check(busy == 1'b0, "abort_beats_arm", busy, 0);

        // Abort in READ after 5 transfers
        stim = {};
        repeat (120) stim.push_back(samp_t'($urandom));
        ok = model(stim, 2'b11, 8'h00, 3, 0, exp);
        run_capture(stim, exp, 2'b11, 8'h00, 3, 0, 70, 2, 5, 0);

`ifdef ADC_DECIM_EN
        ok = model(ramp, 2'b11, 8'h00, 0, 2, exp);
        run_capture(ramp, exp, 2'b11, 8'h00, 0, 2, 100, 0, -1, 0);
`endif

        // Randomized captures
        for (int t = 0; t < 20; t++) begin
            logic [1:0] mode;
            samp_t lvl;
            int pre, dec, tries;
            pre = $urandom_range(0, DEPTH - 1);
            dec = $urandom_range(0, MAXDEC);
            ok = 0; tries = 0;
            while (!ok && tries < 5) begin
                mode = 2'($urandom); lvl = samp_t'($urandom);
                stim = {};
                repeat (250) stim.push_back(samp_t'($urandom));
                ok = model(stim, mode, lvl, pre, dec, exp);
                tries++;
            end
            if (!ok) begin mode = 2'b11; ok = model(stim, mode, lvl, pre, dec, exp); end
            run_capture(stim, exp, mode, lvl, pre, dec, $urandom_range(40, 100),
                        $urandom_range(0, 2), -1, 0);
        end

        repeat (4) @(posedge adc_clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
